key_debounce_tick: RTL and testbench

//   Consumer end of the periodic tick from the clock divider. Debounces one raw

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/key_debounce_tick.sv | 120 ++++++++++++
 tb/tb_key_debounce_tick.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: state encoding and product tick-rate constants shared by the key debouncers
package debounce_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_REL_CHK   = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        PRESS_CHK = ST_PRESS_CHK,
        HELD      = ST_HELD,
        REL_CHK   = ST_REL_CHK
    } deb_state_e;

    localparam int TICK_HZ          = 100;
    localparam int STABLE_TICKS_DEF = 2;
    localparam int LONG_TICKS_DEF   = 100;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous inputs, clears to 0 on reset
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debounce_tick.sv
// key_debounce_tick: tick-sampled push-button debouncer with press, release and long-press pulses
module key_debounce_tick
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_TICKS);
    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_TICKS);

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] deb_q, deb_d, long_q, long_d;
    logic [CNT_W-1:0] deb_inc, long_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             lng_q, lng_d;
    logic             key_s;

    sync_2ff #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (key_in),
        .q_o (key_s)
    );

    assign deb_inc  = deb_q + 1'b1;
    assign long_inc = long_q + 1'b1;

    // A key change always wins over a coincident tick: the CHK states bail out before counting.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        long_d  = long_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        lng_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d = PRESS_CHK;
                    deb_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_s) begin
                    state_d = IDLE;
                end else if (tick) begin
                    deb_d = deb_inc;
                    if (deb_inc == STABLE_C) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        long_d  = '0;
                    end
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d = REL_CHK;
                    deb_d   = '0;
                end else if (tick && long_q != LONG_C) begin
                    long_d = long_inc;
                    lng_d  = (long_inc == LONG_C);
                end
            end
            REL_CHK: begin
                if (key_s) begin
                    state_d = HELD;
                end else if (tick) begin
                    deb_d = deb_inc;
                    if (deb_inc == STABLE_C) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            deb_q   <= '0;
            long_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            lng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            long_q  <= long_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            lng_q   <= lng_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign key_long    = lng_q;

endmodule

// File: tb/tb_key_debounce_tick.sv
// tb_key_debounce_tick: scoreboard bench predicting the exact cycle of every pulse from tick phase
module tb_key_debounce_tick;

    localparam int STB = 2;
    localparam int LNG = 5;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic key_in = 1'b0;
    logic key_level, key_press, key_release, key_long;
    int   n = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   tick_all = 1'b0;
    ev_t  sb[$];

    key_debounce_tick #(
        .STABLE_TICKS (STB),
        .LONG_TICKS   (LNG),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic string kname(input int k);
        return (k == 0) ? "press" : (k == 1) ? "release" : "long";
    endfunction

    function automatic bit tick_at(input int m);
        return tick_all || (m % 10 == 9);
    endfunction

    // cycle index of the k-th tick at or after cycle 'from'
    function automatic int nth_tick(input int from, input int k);
        int m = from;
        int c = 0;
        while (c < k) begin
            if (tick_at(m)) c++;
            m++;
        end
        return m - 1;
    endfunction

    function automatic void push(input int kind, input int cyc);
        int  i = 0;
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        while (i < sb.size() && sb[i].cyc <= cyc) i++;
        sb.insert(i, e);
    endfunction

    task automatic take(input int kind, input logic pulse);
        ev_t e;
        if (sb.size() == 0) begin
            chk({kname(kind), "_unexpected"}, int'(pulse), 0);
        end else begin
            e = sb.pop_front();
            chk({kname(kind), "_kind"}, kind, e.kind);
            chk({kname(kind), "_cycle"}, n, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (key_press) take(0, key_press);
        if (key_release) take(1, key_release);
        if (key_long) take(2, key_long);
    end

    // inputs for cycle n are applied at the preceding negedge and sampled at posedge n
    task automatic drive(input logic k);
        @(negedge clk);
        key_in = k;
        tick   = tick_at(n);
        @(posedge clk);
        n++;
    endtask

    task automatic chk_level(input string tag, input logic exp);
        #1 chk(tag, int'(key_level), int'(exp));
    endtask

    // key_s sees key_in two cycles late, so a change at cycle c reaches the FSM at c+2
    // and ticks from c+3 onward count; pulses show one cycle after the qualifying tick.
    task automatic press_hold(input int hold, input int gofs);
        int c, p, g, d, r, cnt;
        c = n;
        p = nth_tick(c + 3, STB);
        push(0, p + 1);
        g = (gofs >= 0) ? p + gofs : -100;
        d = c + hold;
        cnt = 0;
        for (int m = p + 1; m <= d + 1; m++) begin
            if (cnt < LNG && tick_at(m) && (m < g + 2 || m > g + 12)) begin
                cnt++;
                if (cnt == LNG) push(2, m + 1);
            end
        end
        r = nth_tick(d + 3, STB);
        push(1, r + 1);
        for (int i = 0; i < hold; i++) begin
            drive(!(n >= g && n < g + 10));
            if (gofs >= 0 && n == g + 12) chk_level("level_glitch", 1'b1);
        end
        chk_level("level_hi", 1'b1);
        while (n <= r + 3) drive(1'b0);
        chk_level("level_lo", 1'b0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_level", int'(key_level), 0);
        chk("rst_press", int'(key_press), 0);
        chk("rst_release", int'(key_release), 0);
        chk("rst_long", int'(key_long), 0);
        repeat (3) drive(1'b0);
        #1 rst = 1'b0;
    endtask

    initial begin
        int c, p, t2;
        repeat (2) @(posedge clk);
        #1;
        chk("init_level", int'(key_level), 0);
        chk("init_press", int'(key_press), 0);
        chk("init_release", int'(key_release), 0);
        chk("init_long", int'(key_long), 0);
        rst = 1'b0;
        repeat (5) drive(1'b0);
        press_hold(60, -1);
        repeat (5) begin
            repeat (3) drive(1'b1);
            repeat (3) drive(1'b0);
        end
        press_hold(60, -1);
        press_hold(120, -1);
        press_hold(200, 15);
        repeat (8) drive(1'b1);
        do_reset();
        repeat (60) drive(1'b0);
        c = n;
        p = nth_tick(c + 3, STB);
        push(0, p + 1);
        while (n <= p + 2) drive(1'b1);
        chk_level("level_pre_rst", 1'b1);
        chk("sb_pre_rst", sb.size(), 0);
        do_reset();
        repeat (60) drive(1'b0);
        press_hold(60, -1);
        c  = n;
        t2 = nth_tick(c + 3, STB);
        while (n < t2 - 2) drive(1'b1);
        repeat (40) drive(1'b0);
        chk_level("level_race", 1'b0);
        tick_all = 1'b1;
        press_hold(30, -1);
        tick_all = 1'b0;
        repeat (20) drive(1'b0);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
